multi_shift_unit: RTL and testbench

- Multi-cycle shift sequencer in the CPU execute path.
- Accepts a 16-bit operand, a 2-bit shift code and a 4-bit shift amount.
- Iterates the existing single-bit `shifter` module, one step per clock; the instance is internal, and its `sout` is fed back into an accumulator.
- Produces the final value plus Z/C status for the status register, and lets the datapath perform shifts of 0..15 positions.

---
 rtl/multi_shift_unit.sv | 160 ++++++++++++++++
 tb/tb_multi_shift_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_shift_unit.sv
//==============================================================================
// Module      : multi_shift_unit (with helper module shifter)
// Description : Multi-cycle shift sequencer for the CPU execute path. The
//               operand is shifted one bit per clock by iterating a
//               single-bit shifter on an accumulator. The unit reports the
//               final value together with zero and carry status.
//
//               Ports
//                 clk     in   system clock, rising edge
//                 reset   in   asynchronous active-high reset
//                 start   in   request pulse, sampled when not busy
//                 din     in   [WIDTH-1:0] operand
//                 op      in   [1:0] 00 pass, 01 left, 10 lsr, 11 asr
//                 amt     in   [AMT_W-1:0] number of steps, 0..15
//                 busy    out  high while shift steps are in progress
//                 done    out  one-cycle pulse when dout is valid
//                 dout    out  [WIDTH-1:0] result, held until next accept
//                 zf      out  dout == 0
//                 cf      out  last bit shifted out
//                 sticky  out  OR of all bits shifted out
//
//               Build option: define MULTI_SHIFT_STICKY_EN to build the
//               sticky accumulator; otherwise sticky is tied to 0.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

// Single-bit shifter: one step of the selected shift per evaluation.
module shifter (
    input  logic [15:0] sin,
    input  logic [1:0]  code,
    output logic [15:0] sout
);
    always_comb begin
        sout = sin;
        case (code)
            2'b01:   sout = {sin[14:0], 1'b0};
            2'b10:   sout = {1'b0, sin[15:1]};
            2'b11:   sout = {sin[15], sin[15:1]};
            default: sout = sin;
        endcase
    end
endmodule

module multi_shift_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             zf,
    output logic             cf,
    output logic             sticky
);
    localparam logic [1:0]       c_st_idle  = 2'd0;
    localparam logic [1:0]       c_st_shift = 2'd1;
    localparam logic [1:0]       c_st_done  = 2'd2;
    localparam logic [AMT_W-1:0] c_cnt_one  = {{(AMT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_code;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_zf;
    logic             r_cf;
    logic [WIDTH-1:0] w_sout;
    logic             w_out_bit;

    shifter u_shifter (
        .sin  (r_acc),
        .code (r_code),
        .sout (w_sout)
    );

    // Left shifts lose the MSB, both right shifts lose the LSB.
    assign w_out_bit = (r_code == 2'b01) ? r_acc[WIDTH-1] : r_acc[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_acc   <= '0;
            r_code  <= 2'b00;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_zf    <= 1'b1;
            r_cf    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_acc  <= din;
                        r_code <= op;
                        r_cnt  <= amt;
                        r_cf   <= 1'b0;
                        // Zero effective amount completes at the accept edge.
                        if (op == 2'b00 || amt == '0) begin
                            r_dout  <= din;
                            r_zf    <= (din == '0);
                            r_state <= c_st_done;
                        end else begin
                            r_state <= c_st_shift;
                        end
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_shift: begin
                    r_acc <= w_sout;
                    r_cnt <= r_cnt - c_cnt_one;
                    // Counter is never zero here, so the last step is cnt==1.
                    if (r_cnt == c_cnt_one) begin
                        r_dout  <= w_sout;
                        r_zf    <= (w_sout == '0);
                        r_cf    <= w_out_bit;
                        r_state <= c_st_done;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef MULTI_SHIFT_STICKY_EN
    logic r_sticky;
    logic w_accept;

    assign w_accept = start && (r_state != c_st_shift);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= 1'b0;
        end else if (w_accept) begin
            r_sticky <= 1'b0;
        end else if (r_state == c_st_shift) begin
            r_sticky <= r_sticky | w_out_bit;
        end
    end

    assign sticky = r_sticky;
`else
    assign sticky = 1'b0;
`endif

    assign busy = (r_state == c_st_shift);
    assign done = (r_state == c_st_done);
    assign dout = r_dout;
    assign zf   = r_zf;
    assign cf   = r_cf;

endmodule

`default_nettype wire

// File: tb/tb_multi_shift_unit.sv
//==============================================================================
// Module      : tb_multi_shift_unit
// Description : Self-checking bench for multi_shift_unit. Directed cases and
//               random operations are compared against an arithmetic model.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_multi_shift_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] din;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic        zf;
    logic        cf;
    logic        sticky;

    int total = 0;
    int bad   = 0;

    multi_shift_unit #(.WIDTH(16), .AMT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .din    (din),
        .op     (op),
        .amt    (amt),
        .busy   (busy),
        .done   (done),
        .dout   (dout),
        .zf     (zf),
        .cf     (cf),
        .sticky (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-operation reference: one arithmetic shift by the effective amount.
    task automatic model(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a,
                         output int n, output logic [15:0] r, output logic c, output logic s);
        logic [31:0] mask;
        n = (o == 2'b00) ? 0 : int'(a);
        r = d; c = 1'b0; s = 1'b0;
        mask = (32'h1 << n) - 32'h1;
        if (n > 0) begin
            case (o)
                2'b01: begin
                    r = d << n;
                    c = d[16-n];
                    s = |(d >> (16-n));
                end
                2'b10: begin
                    r = d >> n;
                    c = d[n-1];
                    s = |({16'h0, d} & mask);
                end
                default: begin
                    r = $unsigned($signed(d) >>> n);
                    c = d[n-1];
                    s = |({16'h0, d} & mask);
                end
            endcase
        end
`ifndef MULTI_SHIFT_STICKY_EN
        s = 1'b0;
`endif
    endtask

    // Present an operation at the current negedge; start drops after the edge.
    task automatic do_start(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a);
        din = d; op = o; amt = a; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Sample at negedges until done, counting busy cycles; bounded wait.
    task automatic wait_done(input string tag, output int bcnt);
        bit seen;
        bcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcnt++;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] d, input logic [1:0] o,
                                input logic [3:0] a, input int bcnt);
        int n; logic [15:0] r; logic c; logic s;
        model(d, o, a, n, r, c, s);
        check({tag, "_busy"},   bcnt, n);
        check({tag, "_dout"},   dout, r);
        check({tag, "_zf"},     zf, (r == 16'h0));
        check({tag, "_cf"},     cf, c);
        check({tag, "_sticky"}, sticky, s);
    endtask

    task automatic run_op(input string tag, input logic [15:0] d, input logic [1:0] o,
                          input logic [3:0] a);
        int bcnt;
        @(negedge clk);
        do_start(d, o, a);
        wait_done(tag, bcnt);
        check_result(tag, d, o, a, bcnt);
        @(negedge clk);
        check({tag, "_done_drop"}, done, 1'b0);
    endtask

    initial begin
        int bcnt;
        int dcount;
        logic [15:0] rd;
        logic [1:0]  ro;
        logic [3:0]  ra;

        reset = 1'b1; start = 1'b0; din = '0; op = '0; amt = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",   busy,   1'b0);
        check("rst_done",   done,   1'b0);
        check("rst_dout",   dout,   16'h0);
        check("rst_zf",     zf,     1'b1);
        check("rst_cf",     cf,     1'b0);
        check("rst_sticky", sticky, 1'b0);
        reset = 1'b0;

        run_op("lsl1",  16'h8001, 2'b01, 4'd1);
        run_op("asr4",  16'h8000, 2'b11, 4'd4);
        run_op("lsr3",  16'h0001, 2'b10, 4'd3);
        run_op("amt0",  16'h1234, 2'b01, 4'd0);
        run_op("pass",  16'h1234, 2'b00, 4'd5);
        run_op("lsl15", 16'hFFFF, 2'b01, 4'd15);
        run_op("asr15", 16'h7FFF, 2'b11, 4'd15);

        // Start pulsed during SHIFT is ignored.
        @(negedge clk);
        do_start(16'h00FF, 2'b01, 4'd8);
        @(negedge clk);
        check("ign_busy", busy, 1'b1);
        din = 16'hFFFF; op = 2'b10; amt = 4'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ign", bcnt);
        check("ign_busy_rest", bcnt, 7);
        check("ign_dout", dout, 16'hFF00);
        check("ign_cf",   cf,   1'b0);

        // Back-to-back accept in the DONE cycle.
        do_start(16'hC003, 2'b10, 4'd2);
        wait_done("b2b", bcnt);
        check_result("b2b", 16'hC003, 2'b10, 4'd2, bcnt);
        do_start(16'h0005, 2'b00, 4'd3);
        wait_done("b2b0", bcnt);
        check_result("b2b0", 16'h0005, 2'b00, 4'd3, bcnt);

        // Random operations against the model.
        for (int k = 0; k < 40; k++) begin
            rd = 16'($urandom);
            ro = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 15));
            run_op("rnd", rd, ro, ra);
        end

        // Asynchronous reset mid-SHIFT aborts the operation.
        @(negedge clk);
        do_start(16'hAAAA, 2'b01, 4'd10);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_dout", dout, 16'h0);
        check("arst_zf",   zf,   1'b1);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("arst_no_done", dcount, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
